dmem_burst_responder: RTL and testbench
=======================================

// Module: dmem_burst_responder
// PURPOSE
//  Memory-side responder to the CPU/cache data-memory request interface. Accepts single-word
//  read/write requests and line-fill burst reads, returns read data after a fixed pipeline
//  latency. Replaces the zero-latency data memory for Phase 3 cache-miss handling.
// PARAMETERS
//  ADDR_W     16  byte-address width; storage = 2^(ADDR_W-1) 16-bit words
//  LATENCY    4   cycles from request acceptance to rsp_valid (>=1)
//  BURST_LEN  8   words per burst read (power of 2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       responder can accept (high only in IDLE)
//  req_wr       in   1       1 = single-word write, 0 = read
//  req_burst    in   1       1 = burst read of BURST_LEN words (ignored when req_wr=1)
//  req_addr     in   ADDR_W  byte address; bit0 ignored
//  req_wdata    in   16      write data
//  rsp_valid    out  1       read data valid this cycle
//  rsp_data     out  16      read data
//  rsp_idx      out  log2(BURST_LEN)  word index within burst (0 for single reads)
//  rsp_last     out  1       final response of a request (single read or last burst word)
//  busy         out  1       any request issuing or any read in flight
// BEHAVIOUR
//  - Reset (async): req_ready=0 during rst_n low, 1 first cycle after; rsp_valid/rsp_last/busy=0,
//    rsp_data=0, rsp_idx=0; FSM=IDLE; pipeline valid bits cleared. Array contents NOT reset.
//  - Accept when req_valid & req_ready at posedge. FSM: IDLE -> ISSUE (burst) -> DRAIN -> IDLE;
//    single read: IDLE -> DRAIN -> IDLE; write: stays IDLE.
//  - Write: array updated at accepting edge; no response; read accepted next cycle sees new data.
//  - Single read: array read at accepting edge, shifted through LATENCY-stage pipe; rsp_valid
//    exactly LATENCY cycles after acceptance, rsp_last=1, rsp_idx=0.
//  - Burst: base = req_addr with low log2(BURST_LEN)+1 bits cleared (line-aligned). ISSUE reads
//    one word per cycle, addr = base + 2*i, i = 0..BURST_LEN-1 (acceptance cycle issues i=0).
//    Responses back-to-back, word i at acceptance+LATENCY+i; rsp_last with i=BURST_LEN-1.
//    Address arithmetic is ADDR_W-bit; burst never crosses the aligned line, no wrap needed.
//  - DRAIN: wait until pipe empty, then IDLE. req_ready=0 in ISSUE and DRAIN; requests ignored.
//  - busy = (state!=IDLE) | any pipe stage valid.
//  - rsp_data/rsp_idx hold last value when rsp_valid=0.
//  - rst_n low mid-burst: in-flight responses dropped, no rsp_valid after release.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: adds output req_err (1 bit, reset 0). Request with req_addr[0]=1
//   is accepted but not executed (no write, no response); req_err pulses 1 cycle after acceptance.
//  Not defined: no req_err port; req_addr[0] silently ignored.
// STRUCTURE
//  Shared package/include: FSM state encoding (ST_IDLE, ST_ISSUE, ST_DRAIN), burst index width
//   constant, default LATENCY/BURST_LEN.
//  Sub-module rsp_pipe: LATENCY-deep shift register of {valid, last, idx, data}; one instance.
//  Storage array and FSM/issue counter in this module.
// TESTING
//  1 Write 0x1234 @0x0010, read @0x0010 next cycle -> rsp_valid 4 cycles later, data 0x1234, last=1.
//  2 Preload 0x0020..0x002E with 0xA0..0xA7; burst read @0x0026 -> 8 rsp cycles consecutive,
//    data 0xA0..0xA7, idx 0..7, last only on idx 7; req_ready low from accept until pipe empty.
//  3 req_valid held during burst -> no accept, no array change; accepted first IDLE cycle.
//  4 rst_n low at 2nd burst response -> all outputs 0 immediately; no rsp_valid after release.
//  5 Back-to-back single reads every DRAIN exit -> each returns at +4, busy low only between.
//  6 DMEM_ALIGN_CHECK_EN: write @0x0011 -> req_err pulse, word @0x0010 unchanged, no rsp_valid.

Source files
------------

// File: rtl/dmem_burst_responder_pkg.sv
// Shared definitions for the data-memory burst responder: FSM encoding, widths, default sizing.
package dmem_burst_responder_pkg;

   localparam int unsigned DATA_W        = 16;
   localparam int unsigned DEF_LATENCY   = 4;
   localparam int unsigned DEF_BURST_LEN = 8;
   localparam int unsigned BURST_IDX_W   = $clog2(DEF_BURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_burst_responder_rsp_pipe.sv
// Fixed-latency response pipeline; payload fields only advance with a valid beat so the
// output stage holds the last delivered word while idle.
module dmem_burst_responder_rsp_pipe #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IDX_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic              i_last,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_last,
   output logic [IDX_W-1:0]  o_idx,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy_next_c
);

   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_last;
   logic [IDX_W-1:0]  r_idx  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_last  <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_idx[k]  <= '0;
            r_data[k] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_last[0]  <= i_valid & i_last;
         if (i_valid) begin
            r_idx[0]  <= i_idx;
            r_data[0] <= i_data;
         end
         for (int k = 1; k < int'(DEPTH); k++) begin
            r_valid[k] <= r_valid[k-1];
            r_last[k]  <= r_last[k-1];
            if (r_valid[k-1]) begin
               r_idx[k]  <= r_idx[k-1];
               r_data[k] <= r_data[k-1];
            end
         end
      end
   end

   // Something stays in flight after the next edge, ignoring any beat entering at that edge
   always_comb begin
      o_busy_next_c = 1'b0;
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
         o_busy_next_c = o_busy_next_c | r_valid[k];
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_last  = r_last[DEPTH-1];
   assign o_idx   = r_idx[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/dmem_burst_responder.sv
// Memory-side responder for single-word reads/writes and line-fill burst reads with fixed latency.
// Define DMEM_ALIGN_CHECK_EN to add req_err and reject odd byte addresses. BURST_LEN >= 2.
module dmem_burst_responder
   import dmem_burst_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned LATENCY   = DEF_LATENCY,
   parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_wr,
   input  logic                         req_burst,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   output logic                         rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic [$clog2(BURST_LEN)-1:0] rsp_idx,
   output logic                         rsp_last,
   output logic                         busy
`ifdef DMEM_ALIGN_CHECK_EN
   ,
   output logic                         req_err
`endif
);

   localparam int unsigned IDX_W   = $clog2(BURST_LEN);
   localparam int unsigned WADDR_W = ADDR_W - 1;
   localparam int unsigned LINE_W  = WADDR_W - IDX_W;
   localparam int unsigned DEPTH   = 1 << WADDR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic               r_req_ready;
   logic               r_busy;
   logic [IDX_W-1:0]   r_cnt;
   logic [LINE_W-1:0]  r_line;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_accept;
   logic               w_misaligned;
   logic               w_exec;
   logic               w_wr_en;
   logic               w_rd_single;
   logic               w_rd_burst;
   logic               w_iss_valid;
   logic               w_iss_last;
   logic [IDX_W-1:0]   w_iss_idx;
   logic [WADDR_W-1:0] w_iss_waddr;
   logic [DATA_W-1:0]  w_iss_data;
   logic               w_pipe_busy_next;

   assign w_accept = req_valid & r_req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_misaligned = req_addr[0];
`else
   logic w_unused_addr0;
   assign w_misaligned   = 1'b0;
   assign w_unused_addr0 = req_addr[0];
`endif

   assign w_exec      = w_accept & ~w_misaligned;
   assign w_wr_en     = w_exec & req_wr;
   assign w_rd_single = w_exec & ~req_wr & ~req_burst;
   assign w_rd_burst  = w_exec & ~req_wr & req_burst;

   // Next state and the read issued into the pipe this cycle
   always_comb begin
      w_next_state = r_state;
      w_iss_valid  = 1'b0;
      w_iss_last   = 1'b0;
      w_iss_idx    = '0;
      w_iss_waddr  = req_addr[ADDR_W-1:1];
      case (r_state)
         ST_IDLE: begin
            if (w_rd_single) begin
               w_iss_valid  = 1'b1;
               w_iss_last   = 1'b1;
               w_next_state = ST_DRAIN;
            end else if (w_rd_burst) begin
               w_iss_valid  = 1'b1;
               w_iss_waddr  = {req_addr[ADDR_W-1:IDX_W+1], IDX_W'(0)};
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_iss_valid = 1'b1;
            w_iss_idx   = r_cnt;
            w_iss_waddr = {r_line, r_cnt};
            w_iss_last  = (r_cnt == LAST_IDX);
            if (w_iss_last) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!w_pipe_busy_next) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_cnt       <= '0;
         r_line      <= '0;
      end else begin
         r_state     <= w_next_state;
         r_req_ready <= (w_next_state == ST_IDLE);
         r_busy      <= (w_next_state != ST_IDLE) | w_iss_valid | w_pipe_busy_next;
         if (w_rd_burst) begin
            r_cnt  <= IDX_W'(1);
            r_line <= req_addr[ADDR_W-1:IDX_W+1];
         end else if (r_state == ST_ISSUE) begin
            r_cnt <= r_cnt + IDX_W'(1);
         end
      end
   end

   // Storage keeps its contents across reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[req_addr[ADDR_W-1:1]] <= req_wdata;
      end
   end

   assign w_iss_data = r_mem[w_iss_waddr];

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_req_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_err <= 1'b0;
      end else begin
         r_req_err <= w_accept & req_addr[0];
      end
   end
   assign req_err = r_req_err;
`endif

   dmem_burst_responder_rsp_pipe #(
      .DEPTH  (LATENCY),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_rsp_pipe (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_valid       (w_iss_valid),
      .i_last        (w_iss_last),
      .i_idx         (w_iss_idx),
      .i_data        (w_iss_data),
      .o_valid       (rsp_valid),
      .o_last        (rsp_last),
      .o_idx         (rsp_idx),
      .o_data        (rsp_data),
      .o_busy_next_c (w_pipe_busy_next)
   );

   assign req_ready = r_req_ready;
   assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_burst_responder.sv
// Self-checking bench for dmem_burst_responder against a transaction-level memory/response model.
`timescale 1ns/1ps
module tb_dmem_burst_responder;

   localparam int LAT   = 4;
   localparam int BL    = 8;
   localparam int IDX_W = 3;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct packed {
      int               cyc;
      logic [15:0]      data;
      logic [IDX_W-1:0] idx;
      logic             last;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_wr = 1'b0;
   logic             req_burst = 1'b0;
   logic [15:0]      req_addr = '0;
   logic [15:0]      req_wdata = '0;
   logic             req_ready;
   logic             rsp_valid;
   logic [15:0]      rsp_data;
   logic [IDX_W-1:0] rsp_idx;
   logic             rsp_last;
   logic             busy;
`ifdef DMEM_ALIGN_CHECK_EN
   logic             req_err;
`endif

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   busy_low = 0;
   bit   busy_win = 1'b0;
   rsp_t exp_q[$];
   rsp_t obs_q[$];
   logic [15:0] m_mem [int];

   dmem_burst_responder #(.ADDR_W(16), .LATENCY(LAT), .BURST_LEN(BL)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_burst (req_burst),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_idx   (rsp_idx),
      .rsp_last  (rsp_last),
      .busy      (busy)
`ifdef DMEM_ALIGN_CHECK_EN
      ,
      .req_err   (req_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every delivered response with the edge count at which it is sampled
   always @(negedge clk) begin
      if (rst_n && rsp_valid) obs_q.push_back(rsp_t'{cyc, rsp_data, rsp_idx, rsp_last});
      if (busy_win && !busy) busy_low++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Reference: request accepted at edge acc; response i is on the bus LAT+i cycles later
   task automatic model_accept(input logic wr, input logic burst, input logic [15:0] addr,
                               input logic [15:0] data, input int acc);
      logic [14:0] w;
      logic [14:0] base;
      w = addr[15:1];
      if (ALIGN && addr[0]) return;
      if (wr) m_mem[int'(w)] = data;
      else if (!burst) exp_q.push_back(rsp_t'{acc + LAT - 1, m_mem[int'(w)], IDX_W'(0), 1'b1});
      else begin
         base = w & ~15'(BL - 1);
         for (int i = 0; i < BL; i++)
            exp_q.push_back(rsp_t'{acc + LAT - 1 + i, m_mem[int'(base) + i], IDX_W'(i), i == BL - 1});
      end
   endtask

   task automatic do_req(input logic wr, input logic burst, input logic [15:0] addr,
                         input logic [15:0] data, output int acc, output bit ok);
      int n = 0;
      req_valid = 1'b1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = data;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      ok = (req_ready === 1'b1);
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
      if (ok) model_accept(wr, burst, addr, data, acc);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({req_ready, rsp_valid, rsp_last, busy} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/valid/last/busy=%b expected 0000", {req_ready, rsp_valid, rsp_last, busy});
      end
      n_chk++;
      if ({rsp_data, rsp_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: data=%h idx=%0d expected 0/0", rsp_data, rsp_idx);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      n_chk++;
      if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: req_err=%b expected 0", req_err); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b expected 1/0", req_ready, busy);
      end
   endtask

   task automatic test_write_read();
      int a1, a2; bit ok1, ok2;
      obs_q.delete(); exp_q.delete();
      do_req(1'b1, 1'b0, 16'h0010, 16'h1234, a1, ok1);
      do_req(1'b0, 1'b0, 16'h0010, 16'h0000, a2, ok2);
      n_chk++;
      if (!(ok1 && ok2) || a2 != a1 + 1) begin
         n_fail++;
         $display("FAIL wr_rd_accept: read accepted %0d cycles after write, expected 1", a2 - a1);
      end
      repeat (LAT + 4) @(negedge clk);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL wr_rd_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL wr_rd_rsp[%0d]: got cyc=%0d data=%h idx=%0d last=%b expected cyc=%0d data=%h idx=%0d last=%b",
                     i, obs_q[i].cyc, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                     exp_q[i].cyc, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
         end
      end
   endtask

   task automatic test_burst_hold();
      int a, n, rdy_cyc; bit ok, all_ok, held_ok;
      all_ok = 1'b1;
      for (int i = 0; i < BL; i++) begin
         do_req(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'h00A0 + i), a, ok);
         all_ok &= ok;
      end
      obs_q.delete(); exp_q.delete();
      do_req(1'b0, 1'b1, 16'h0026, 16'h0000, a, ok);
      all_ok &= ok;
      // Hold a write to the last word of the line while the burst is still being served
      req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b0; req_addr = 16'h002E; req_wdata = 16'h5555;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      rdy_cyc = cyc;
      held_ok = (req_ready === 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      if (held_ok) model_accept(1'b1, 1'b0, 16'h002E, 16'h5555, cyc);
      n_chk++;
      if (!held_ok || rdy_cyc != a + LAT + BL - 1) begin
         n_fail++;
         $display("FAIL burst_ready: ready returned at edge %0d expected %0d", rdy_cyc, a + LAT + BL - 1);
      end
      do_req(1'b0, 1'b0, 16'h002E, 16'h0000, a, ok);
      all_ok &= ok;
      repeat (LAT + 4) @(negedge clk);
      n_chk++;
      if (!all_ok) begin n_fail++; $display("FAIL burst_req_timeout: ok=0 expected 1"); end
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL burst_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL burst_rsp[%0d]: got cyc=%0d data=%h idx=%0d last=%b expected cyc=%0d data=%h idx=%0d last=%b",
                     i, obs_q[i].cyc, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                     exp_q[i].cyc, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int a, n; bit ok;
      do_req(1'b0, 1'b1, 16'h0020, 16'h0000, a, ok);
      n = 0;
      while (!(rsp_valid === 1'b1 && rsp_idx === IDX_W'(1)) && n < 50) begin @(negedge clk); n++; end
      n_chk++;
      if (!ok || n >= 50) begin n_fail++; $display("FAIL rstmid_second_rsp: not seen within %0d cycles", n); end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({req_ready, rsp_valid, rsp_last, busy, rsp_data, rsp_idx} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: ready=%b valid=%b last=%b busy=%b data=%h idx=%0d expected all 0",
                  req_ready, rsp_valid, rsp_last, busy, rsp_data, rsp_idx);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      repeat (20) @(negedge clk);
      n_chk++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL rstmid_no_rsp: got %0d responses after release expected 0", obs_q.size());
      end
      n_chk++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_idle: ready=%b busy=%b expected 1/0", req_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      int a; bit ok, all_ok;
      all_ok = 1'b1;
      obs_q.delete(); exp_q.delete();
      busy_low = 0;
      for (int k = 0; k < 5; k++) begin
         do_req(1'b0, 1'b0, 16'(16'h0020 + 2 * $urandom_range(0, 6)), 16'h0000, a, ok);
         all_ok &= ok;
         if (k == 0) busy_win = 1'b1;
      end
      repeat (LAT - 1) @(negedge clk);
      busy_win = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if (!all_ok || busy_low != 4) begin
         n_fail++; $display("FAIL b2b_busy: busy low for %0d cycles between reads expected 4 (ok=%b)", busy_low, all_ok);
      end
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_rsp[%0d]: got cyc=%0d data=%h idx=%0d last=%b expected cyc=%0d data=%h idx=%0d last=%b",
                     i, obs_q[i].cyc, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                     exp_q[i].cyc, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
         end
      end
   endtask

   task automatic test_random();
      int a, op; bit ok, all_ok;
      logic [15:0] addr;
      all_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         do_req(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'($urandom), a, ok);
         all_ok &= ok;
      end
      obs_q.delete(); exp_q.delete();
      for (int t = 0; t < 40; t++) begin
         op   = int'($urandom_range(0, 2));
         addr = 16'(16'h0100 + 2 * $urandom_range(0, 31));
         do_req(op == 0, op == 2, addr, 16'($urandom), a, ok);
         all_ok &= ok;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (LAT + BL + 4) @(negedge clk);
      n_chk++;
      if (!all_ok) begin n_fail++; $display("FAIL rand_req_timeout: ok=0 expected 1"); end
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d]: got cyc=%0d data=%h idx=%0d last=%b expected cyc=%0d data=%h idx=%0d last=%b",
                     i, obs_q[i].cyc, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                     exp_q[i].cyc, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
         end
      end
   endtask

   task automatic test_align();
      int a; bit ok, all_ok;
      all_ok = 1'b1;
      obs_q.delete(); exp_q.delete();
      do_req(1'b1, 1'b0, 16'h0010, 16'h1234, a, ok);
      all_ok &= ok;
`ifdef DMEM_ALIGN_CHECK_EN
      do_req(1'b1, 1'b0, 16'h0011, 16'hBEEF, a, ok);
      all_ok &= ok;
      n_chk++;
      if (req_err !== 1'b1) begin n_fail++; $display("FAIL align_err_pulse: req_err=%b expected 1", req_err); end
      @(negedge clk);
      n_chk++;
      if (req_err !== 1'b0) begin n_fail++; $display("FAIL align_err_clear: req_err=%b expected 0", req_err); end
      do_req(1'b0, 1'b0, 16'h0011, 16'h0000, a, ok);
      all_ok &= ok;
      n_chk++;
      if (req_err !== 1'b1) begin n_fail++; $display("FAIL align_rd_err: req_err=%b expected 1", req_err); end
`endif
      do_req(1'b0, 1'b0, 16'h0010, 16'h0000, a, ok);
      all_ok &= ok;
      do_req(1'b0, 1'b0, 16'h0011, 16'h0000, a, ok);
      all_ok &= ok;
      repeat (LAT + 4) @(negedge clk);
      n_chk++;
      if (!all_ok) begin n_fail++; $display("FAIL align_req_timeout: ok=0 expected 1"); end
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL align_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL align_rsp[%0d]: got cyc=%0d data=%h idx=%0d last=%b expected cyc=%0d data=%h idx=%0d last=%b",
                     i, obs_q[i].cyc, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                     exp_q[i].cyc, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_burst_hold();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      test_align();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
